// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64I+Zba decode stage: register file, control decoder, immediate generator.
// Optional REGFILE_BYPASS_EN: write-through from W to the D-stage read ports.
`timescale 1ns/1ps
module decode_stage #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     Instr_D,
   input  logic [XLEN-1:0] PC_D,
   input  logic            RegWrite_W,
   input  logic [4:0]      Rd_W,
   input  logic [XLEN-1:0] Result_W,
   output logic [XLEN-1:0] RD1_D,
   output logic [XLEN-1:0] RD2_D,
   output logic [XLEN-1:0] ImmExt_D,
   output logic [4:0]      Rd_D,
   output logic [4:0]      Rs1_D,
   output logic [4:0]      Rs2_D,
   output logic            RegWrite_D,
   output logic [1:0]      ResultSrc_D,
   output logic            MemWrite_D,
   output logic [3:0]      ALUControl_D,
   output logic            ALUSrc_D,
   output logic            Branch_D,
   output logic            Jump_D,
   output logic            IllegalInstr_D
);
   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                          ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                          ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                          ALU_SRA = 4'b1001, ALU_SH1 = 4'b1010, ALU_SH2 = 4'b1011,
                          ALU_SH3 = 4'b1100, ALU_PASSB = 4'b1110;
   localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;

   logic [XLEN-1:0] regs [0:NREGS-1];
   logic [6:0]      opcode, funct7;
   logic [5:0]      funct6;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
   logic            unused_pc;

   // PC_D only travels alongside Instr_D to the D/E register.
   assign unused_pc = ^PC_D;

   assign Rd_D   = Instr_D[11:7];
   assign Rs1_D  = Instr_D[19:15];
   assign Rs2_D  = Instr_D[24:20];
   assign opcode = Instr_D[6:0];
   assign funct3 = Instr_D[14:12];
   assign funct7 = Instr_D[31:25];
   assign funct6 = Instr_D[31:26];

   assign imm_i  = {{52{Instr_D[31]}}, Instr_D[31:20]};
   assign imm_s  = {{52{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
   assign imm_b  = {{52{Instr_D[31]}}, Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
   assign imm_j  = {{44{Instr_D[31]}}, Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};
   assign imm_u  = {{32{Instr_D[31]}}, Instr_D[31:12], 12'b0};
   assign imm_sh = {58'b0, Instr_D[25:20]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (RegWrite_W && (Rd_W != 5'd0)) begin
         regs[Rd_W] <= Result_W;
      end
   end

   always_comb begin
      RD1_D = (Rs1_D == 5'd0) ? '0 : regs[Rs1_D];
      RD2_D = (Rs2_D == 5'd0) ? '0 : regs[Rs2_D];
`ifdef REGFILE_BYPASS_EN
      if (rst && RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_D)) RD1_D = Result_W;
      if (rst && RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_D)) RD2_D = Result_W;
`endif
   end

   always_comb begin
      RegWrite_D     = 1'b0;
      ResultSrc_D    = RES_ALU;
      MemWrite_D     = 1'b0;
      ALUControl_D   = ALU_ADD;
      ALUSrc_D       = 1'b0;
      Branch_D       = 1'b0;
      Jump_D         = 1'b0;
      ImmExt_D       = '0;
      IllegalInstr_D = 1'b1;
      case (opcode)
         7'h33: begin
            IllegalInstr_D = 1'b0;
            RegWrite_D     = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: ALUControl_D = ALU_ADD;
               10'b0100000_000: ALUControl_D = ALU_SUB;
               10'b0000000_001: ALUControl_D = ALU_SLL;
               10'b0000000_010: ALUControl_D = ALU_SLT;
               10'b0000000_011: ALUControl_D = ALU_SLTU;
               10'b0000000_100: ALUControl_D = ALU_XOR;
               10'b0000000_101: ALUControl_D = ALU_SRL;
               10'b0100000_101: ALUControl_D = ALU_SRA;
               10'b0000000_110: ALUControl_D = ALU_OR;
               10'b0000000_111: ALUControl_D = ALU_AND;
               10'b0010000_010: ALUControl_D = ALU_SH1;
               10'b0010000_100: ALUControl_D = ALU_SH2;
               10'b0010000_110: ALUControl_D = ALU_SH3;
               default:         IllegalInstr_D = 1'b1;
            endcase
         end
         7'h13: begin
            IllegalInstr_D = 1'b0;
            RegWrite_D     = 1'b1;
            ALUSrc_D       = 1'b1;
            ImmExt_D       = imm_i;
            case (funct3)
               3'b000: ALUControl_D = ALU_ADD;
               3'b010: ALUControl_D = ALU_SLT;
               3'b011: ALUControl_D = ALU_SLTU;
               3'b100: ALUControl_D = ALU_XOR;
               3'b110: ALUControl_D = ALU_OR;
               3'b111: ALUControl_D = ALU_AND;
               3'b001: begin
                  ImmExt_D     = imm_sh;
                  ALUControl_D = ALU_SLL;
                  if (funct6 != 6'b000000) IllegalInstr_D = 1'b1;
               end
               default: begin
                  ImmExt_D = imm_sh;
                  if (funct6 == 6'b000000)      ALUControl_D = ALU_SRL;
                  else if (funct6 == 6'b010000) ALUControl_D = ALU_SRA;
                  else                          IllegalInstr_D = 1'b1;
               end
            endcase
         end
         7'h03: if (funct3 == 3'b011) begin
            IllegalInstr_D = 1'b0;
            RegWrite_D     = 1'b1;
            ALUSrc_D       = 1'b1;
            ResultSrc_D    = RES_MEM;
            ImmExt_D       = imm_i;
         end
         7'h23: if (funct3 == 3'b011) begin
            IllegalInstr_D = 1'b0;
            MemWrite_D     = 1'b1;
            ALUSrc_D       = 1'b1;
            ImmExt_D       = imm_s;
         end
         7'h63: if (funct3 == 3'b000) begin
            IllegalInstr_D = 1'b0;
            Branch_D       = 1'b1;
            ALUControl_D   = ALU_SUB;
            ImmExt_D       = imm_b;
         end
         7'h6F: begin
            IllegalInstr_D = 1'b0;
            Jump_D         = 1'b1;
            RegWrite_D     = 1'b1;
            ResultSrc_D    = RES_PC4;
            ImmExt_D       = imm_j;
         end
         7'h37: begin
            IllegalInstr_D = 1'b0;
            RegWrite_D     = 1'b1;
            ALUSrc_D       = 1'b1;
            ALUControl_D   = ALU_PASSB;
            ImmExt_D       = imm_u;
         end
         default: IllegalInstr_D = 1'b1;
      endcase
      // An unsupported encoding leaves the pipeline as a bubble.
      if (IllegalInstr_D) begin
         RegWrite_D   = 1'b0;
         ResultSrc_D  = RES_ALU;
         MemWrite_D   = 1'b0;
         ALUControl_D = ALU_ADD;
         ALUSrc_D     = 1'b0;
         Branch_D     = 1'b0;
         Jump_D       = 1'b0;
         ImmExt_D     = '0;
      end
   end
endmodule
